slave_mem: RTL and testbench

SLAVE_MEM -- requirements
Module: slave_mem

---
 rtl/slave_mem.sv | 187 ++++++++++++++++++
 tb/tb_slave_mem.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/slave_mem.sv
// Simple word-addressed memory slave with independent write and read channels and fixed wait states.
// Define SLAVE_MEM_INIT_EN to preload word i with (i ^ 32'hA5A5A5A5); otherwise contents start unknown.
module slave_mem #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                    iCLK,
   input  logic                    iRST,
   input  logic                    w_REQ,
   input  logic [ADDR_WIDTH-1:0]   w_ADDR,
   input  logic [DATA_WIDTH-1:0]   w_DATA,
   input  logic [DATA_WIDTH/8-1:0] w_STRB,
   output logic                    w_ACK,
   output logic                    w_ERR,
   input  logic                    r_REQ,
   input  logic [ADDR_WIDTH-1:0]   r_ADDR,
   output logic [DATA_WIDTH-1:0]   r_DATA,
   output logic                    r_VALID,
   output logic                    r_ERR
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   typedef logic [DATA_WIDTH-1:0] memT [DEPTH];

`ifdef SLAVE_MEM_INIT_EN
   function automatic memT initMem();
      memT m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = DATA_WIDTH'(32'hA5A5A5A5 ^ 32'(i));
      end
      return m;
   endfunction
   memT mem = initMem();
`else
   memT mem;
`endif

   logic [1:0]            wState_q, wState_d, rState_q, rState_d;
   logic [3:0]            wCnt_q, wCnt_d, rCnt_q, rCnt_d;
   logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d, rAddr_q, rAddr_d;
   logic [DATA_WIDTH-1:0] wData_q, wData_d;
   logic [NB-1:0]         wStrb_q, wStrb_d;
   logic                  wErr_q, rErr_q;
   logic [DATA_WIDTH-1:0] rData_q;

   logic                  wCommit, rCommit;
   logic [ADDR_WIDTH-1:0] wCommitAddr, rCommitAddr;
   logic [DATA_WIDTH-1:0] wCommitData;
   logic [NB-1:0]         wCommitStrb;
   logic                  wInRange, rInRange;

   // With no wait states the commit happens on the sampling edge, so the live inputs are used directly.
   always_comb begin
      wState_d    = wState_q;
      wCnt_d      = wCnt_q;
      wAddr_d     = wAddr_q;
      wData_d     = wData_q;
      wStrb_d     = wStrb_q;
      wCommit     = 1'b0;
      wCommitAddr = wAddr_q;
      wCommitData = wData_q;
      wCommitStrb = wStrb_q;
      case (wState_q)
         IDLE: begin
            if (w_REQ) begin
               wAddr_d = w_ADDR;
               wData_d = w_DATA;
               wStrb_d = w_STRB;
               if (HAS_WAIT) begin
                  wState_d = BUSY;
                  wCnt_d   = WAIT_LOAD;
               end else begin
                  wState_d    = RESP;
                  wCommit     = 1'b1;
                  wCommitAddr = w_ADDR;
                  wCommitData = w_DATA;
                  wCommitStrb = w_STRB;
               end
            end
         end
         BUSY: begin
            if (wCnt_q == 4'd0) begin
               wState_d = RESP;
               wCommit  = 1'b1;
            end else begin
               wCnt_d = wCnt_q - 4'd1;
            end
         end
         RESP:    wState_d = IDLE;
         default: wState_d = IDLE;
      endcase
   end

   always_comb begin
      rState_d    = rState_q;
      rCnt_d      = rCnt_q;
      rAddr_d     = rAddr_q;
      rCommit     = 1'b0;
      rCommitAddr = rAddr_q;
      case (rState_q)
         IDLE: begin
            if (r_REQ) begin
               rAddr_d = r_ADDR;
               if (HAS_WAIT) begin
                  rState_d = BUSY;
                  rCnt_d   = WAIT_LOAD;
               end else begin
                  rState_d    = RESP;
                  rCommit     = 1'b1;
                  rCommitAddr = r_ADDR;
               end
            end
         end
         BUSY: begin
            if (rCnt_q == 4'd0) begin
               rState_d = RESP;
               rCommit  = 1'b1;
            end else begin
               rCnt_d = rCnt_q - 4'd1;
            end
         end
         RESP:    rState_d = IDLE;
         default: rState_d = IDLE;
      endcase
   end

   assign wInRange = ((wCommitAddr >> IDX_W) == '0);
   assign rInRange = ((rCommitAddr >> IDX_W) == '0);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wState_q <= IDLE;
         rState_q <= IDLE;
         wCnt_q   <= 4'd0;
         rCnt_q   <= 4'd0;
         wAddr_q  <= '0;
         rAddr_q  <= '0;
         wData_q  <= '0;
         wStrb_q  <= '0;
         wErr_q   <= 1'b0;
         rErr_q   <= 1'b0;
         rData_q  <= '0;
      end else begin
         wState_q <= wState_d;
         rState_q <= rState_d;
         wCnt_q   <= wCnt_d;
         rCnt_q   <= rCnt_d;
         wAddr_q  <= wAddr_d;
         rAddr_q  <= rAddr_d;
         wData_q  <= wData_d;
         wStrb_q  <= wStrb_d;
         wErr_q   <= wCommit && !wInRange;
         rErr_q   <= rCommit && !rInRange;
         if (rCommit) begin
            rData_q <= rInRange ? mem[rCommitAddr[IDX_W-1:0]] : '0;
         end
      end
   end

   // Memory has no reset; the read above sees the pre-write word when both land on one edge.
   always_ff @(posedge iCLK) begin
      if (!iRST && wCommit && wInRange) begin
         for (int b = 0; b < NB; b++) begin
            if (wCommitStrb[b]) begin
               mem[wCommitAddr[IDX_W-1:0]][8*b +: 8] <= wCommitData[8*b +: 8];
            end
         end
      end
   end

   assign w_ACK   = (wState_q == RESP);
   assign w_ERR   = wErr_q;
   assign r_VALID = (rState_q == RESP);
   assign r_ERR   = rErr_q;
   assign r_DATA  = rData_q;

endmodule

// File: tb/tb_slave_mem.sv
// Self-checking bench for slave_mem: directed scenarios plus randomized traffic against an array model.
// A second instance with no wait states covers back-to-back throughput.
module tb_slave_mem;

   localparam int WAIT  = 2;
   localparam int DEPTH = 256;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        wReq, rReq, wAck, wErr, rValid, rErr;
   logic [31:0] wAddr, wData, rAddr, rData;
   logic [3:0]  wStrb;

   logic        w0Req, r0Req, w0Ack, w0Err, r0Valid, r0Err;
   logic [31:0] w0Addr, w0Data, r0Addr, r0Data;
   logic [3:0]  w0Strb;

   logic [31:0] model [DEPTH];
   bit          known [DEPTH];
   int          testsRun  = 0;
   int          failCount = 0;

   always #5 iCLK = ~iCLK;

   slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .w_REQ(wReq), .w_ADDR(wAddr), .w_DATA(wData), .w_STRB(wStrb), .w_ACK(wAck), .w_ERR(wErr),
      .r_REQ(rReq), .r_ADDR(rAddr), .r_DATA(rData), .r_VALID(rValid), .r_ERR(rErr)
   );

   slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .iCLK(iCLK), .iRST(iRST),
      .w_REQ(w0Req), .w_ADDR(w0Addr), .w_DATA(w0Data), .w_STRB(w0Strb), .w_ACK(w0Ack), .w_ERR(w0Err),
      .r_REQ(r0Req), .r_ADDR(r0Addr), .r_DATA(r0Data), .r_VALID(r0Valid), .r_ERR(r0Err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues a write and/or read, scrambles the inputs once captured, and checks timing, errors and data.
   task automatic applyStimulus(input bit doW, input bit doR, input logic [31:0] wa, input logic [31:0] wd,
                                input logic [3:0] ws, input logic [31:0] ra, input bit chkData);
      int          n;
      logic [31:0] expR;
      bit          expRErr;
      expRErr = (ra >= DEPTH);
      expR    = expRErr ? 32'h0 : model[ra[7:0]];
      wAddr = wa; wData = wd; wStrb = ws; wReq = doW;
      rAddr = ra; rReq = doR;
      n = 0;
      do begin
         @(posedge iCLK); #1;
         n++;
         if (n == 1) begin
            wAddr = $urandom; wData = $urandom; wStrb = 4'($urandom); rAddr = $urandom;
         end
      end while (!((doW && wAck) || (doR && rValid)) && n < 20);
      checkOutput("latency", 32'(n), 32'(WAIT + 1));
      if (doW) begin
         checkOutput("w_ACK", {31'b0, wAck}, 32'd1);
         checkOutput("w_ERR", {31'b0, wErr}, {31'b0, (wa >= DEPTH)});
      end
      if (doR) begin
         checkOutput("r_VALID", {31'b0, rValid}, 32'd1);
         checkOutput("r_ERR", {31'b0, rErr}, {31'b0, expRErr});
         if (chkData) checkOutput("r_DATA", rData, expR);
      end
      wReq = 1'b0; rReq = 1'b0;
      if (doW && wa < DEPTH) begin
         for (int b = 0; b < 4; b++) begin
            if (ws[b]) model[wa[7:0]][8*b +: 8] = wd[8*b +: 8];
         end
         if (ws == 4'hF) known[wa[7:0]] = 1'b1;
      end
      @(posedge iCLK); #1;
      checkOutput("pulse end", {28'b0, wAck, wErr, rValid, rErr}, 32'd0);
   endtask

   initial begin
      int          op, pulses;
      logic [31:0] a, b, d;
      iRST = 1'b1;
      wReq = 0; rReq = 0; wAddr = 0; wData = 0; wStrb = 0; rAddr = 0;
      w0Req = 0; r0Req = 0; w0Addr = 0; w0Data = 0; w0Strb = 0; r0Addr = 0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SLAVE_MEM_INIT_EN
         model[i] = 32'(i) ^ 32'hA5A5A5A5;
         known[i] = 1'b1;
`else
         model[i] = 32'h0;
         known[i] = 1'b0;
`endif
      end
      repeat (3) @(posedge iCLK);
      #1;
      checkOutput("reset outputs", {27'b0, wAck, wErr, rValid, rErr, r0Valid}, 32'd0);
      checkOutput("reset r_DATA", rData, 32'd0);
      iRST = 1'b0;

`ifdef SLAVE_MEM_INIT_EN
      applyStimulus(0, 1, 0, 0, 0, 32'h10, 1);
      checkOutput("init word 0x10", rData, 32'hA5A5A5B5);
`endif

      // Byte-strobe merge
      applyStimulus(1, 0, 32'h05, 32'h11223344, 4'hF, 0, 0);
      applyStimulus(1, 0, 32'h05, 32'hAABBCCDD, 4'h5, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 32'h05, 1);
      checkOutput("strobe merge", rData, 32'h11BB33DD);

      // Reset in the middle of a write and a read
      applyStimulus(1, 0, 32'h30, 32'h12345678, 4'hF, 0, 0);
      wAddr = 32'h30; wData = 32'hDEADBEEF; wStrb = 4'hF; wReq = 1'b1;
      rAddr = 32'h30; rReq = 1'b1;
      @(posedge iCLK); #1;
      iRST = 1'b1;
      @(posedge iCLK); #1;
      iRST = 1'b0; wReq = 1'b0; rReq = 1'b0;
      checkOutput("mid-reset outputs", {28'b0, wAck, wErr, rValid, rErr}, 32'd0);
      checkOutput("mid-reset r_DATA", rData, 32'd0);
      pulses = 0;
      repeat (5) begin
         @(posedge iCLK); #1;
         if (wAck || rValid) pulses++;
      end
      checkOutput("no pulse after reset", 32'(pulses), 32'd0);
      applyStimulus(0, 1, 0, 0, 0, 32'h30, 1);

      // Same-edge write and read of one address returns the old word
      applyStimulus(1, 0, 32'h20, 32'h0, 4'hF, 0, 0);
      applyStimulus(1, 1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h20, 1);
      checkOutput("read-before-write", rData, 32'h0);
      applyStimulus(0, 1, 0, 0, 0, 32'h20, 1);
      checkOutput("read after write", rData, 32'hCAFEF00D);

      // Out-of-range accesses
      applyStimulus(1, 0, 32'h00, 32'h0BADF00D, 4'hF, 0, 0);
      applyStimulus(1, 0, 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 32'h00, 1);
      applyStimulus(0, 1, 0, 0, 0, 32'h100, 1);

      // Randomized traffic over a small pool of fully written words
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 32'h40 + 32'(i), $urandom, 4'hF, 0, 0);
      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 3);
         a  = 32'h40 + 32'($urandom_range(0, 7));
         b  = 32'h40 + 32'($urandom_range(0, 7));
         d  = $urandom;
         case (op)
            0: applyStimulus(1, 0, a, d, 4'($urandom), 0, 0);
            1: applyStimulus(0, 1, 0, 0, 0, b, 1);
            2: applyStimulus(1, 1, a, d, 4'($urandom), b, 1);
            default: applyStimulus(1, 1, 32'h100 + 32'($urandom_range(0, 999)), d, 4'hF,
                                   32'h100 + 32'($urandom_range(0, 999)), 1);
         endcase
      end
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0, 0, 32'h40 + 32'(i), 1);

      // Zero-wait instance: a held request completes every second cycle
      r0Addr = 32'h0; r0Req = 1'b1;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge iCLK); #1;
         checkOutput("wait0 r_VALID", {31'b0, r0Valid}, {31'b0, (i % 2 == 0)});
         checkOutput("wait0 r_ERR", {31'b0, r0Err}, 32'd0);
         if (r0Valid) pulses++;
      end
      r0Req = 1'b0;
      checkOutput("wait0 pulse count", 32'(pulses), 32'd3);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
